// File: rtl/voting_tally_ctrl.sv
// Serial ballot collector: dedups voter ids, tallies yes/no, decides strict majority.
// Latency: last ballot or close -> one DECIDE cycle -> done on the following edge.
// Backpressure: ballot_ready is high only while collecting; rejected ballots are still consumed.
module voting_tally_ctrl #(
  parameter int unsigned NUM_VOTERS = 8,
  parameter int unsigned ID_W       = $clog2(NUM_VOTERS),
  parameter int unsigned CNT_W      = $clog2(NUM_VOTERS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             close,
  input  logic             ballot_valid,
  output logic             ballot_ready,
  input  logic [ID_W-1:0]  ballot_id,
  input  logic             ballot_vote,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             tie,
  output logic [CNT_W-1:0] yes_cnt,
  output logic [CNT_W-1:0] no_cnt,
  output logic             dup_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_VOTERS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      yes_q, yes_d, no_q, no_d;
  logic                  result_q, result_d, tie_q, tie_d, dup_q, dup_d;
  logic                  id_ok;

  // With a power-of-two voter count every encodable id is a real voter.
  generate
    if (NUM_VOTERS == (1 << ID_W)) begin : g_id_full
      assign id_ok = 1'b1;
    end else begin : g_id_part
      assign id_ok = (32'(ballot_id) < NUM_VOTERS);
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    yes_d    = yes_q;
    no_d     = no_q;
    result_d = result_q;
    tie_d    = tie_q;
    dup_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_COLLECT;
          mask_d   = '0;
          yes_d    = '0;
          no_d     = '0;
          result_d = 1'b0;
          tie_d    = 1'b0;
        end
      end
      S_COLLECT: begin
        if (ballot_valid) begin
          if (id_ok && !mask_q[ballot_id]) begin
            mask_d = mask_q | (NUM_VOTERS'(1) << ballot_id);
            if (ballot_vote) yes_d = yes_q + 1'b1;
            else             no_d  = no_q + 1'b1;
          end else begin
            dup_d = 1'b1;
          end
        end
        // Looking at the post-update mask lets the final ballot close the election on its own edge.
        if (close || (&mask_d)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        result_d = (yes_q > no_q);
        tie_d    = (yes_q == no_q);
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      yes_q    <= '0;
      no_q     <= '0;
      result_q <= 1'b0;
      tie_q    <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      yes_q    <= yes_d;
      no_q     <= no_d;
      result_q <= result_d;
      tie_q    <= tie_d;
      dup_q    <= dup_d;
    end
  end

  assign ballot_ready = (state_q == S_COLLECT);
  assign busy         = (state_q == S_COLLECT) || (state_q == S_DECIDE);
  assign done         = (state_q == S_DONE);
  assign result       = result_q;
  assign tie          = tie_q;
  assign yes_cnt      = yes_q;
  assign no_cnt       = no_q;
  assign dup_err      = dup_q;

endmodule

// File: tb/tb_voting_tally_ctrl.sv
// Randomized bench for voting_tally_ctrl: an election-level model predicts outcomes into a scoreboard.
module tb_voting_tally_ctrl;
  localparam int N     = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             close = 1'b0;
  logic             ballot_valid = 1'b0;
  logic             ballot_ready;
  logic [ID_W-1:0]  ballot_id = '0;
  logic             ballot_vote = 1'b0;
  logic             busy, done, result, tie, dup_err;
  logic [CNT_W-1:0] yes_cnt, no_cnt;

  voting_tally_ctrl #(.NUM_VOTERS(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .close(close),
    .ballot_valid(ballot_valid), .ballot_ready(ballot_ready),
    .ballot_id(ballot_id), .ballot_vote(ballot_vote),
    .busy(busy), .done(done), .result(result), .tie(tie),
    .yes_cnt(yes_cnt), .no_cnt(no_cnt), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int yes;
    int no;
    int res;
    int tie;
    int dup;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Election-level model: who has voted, running tallies, and where the election stands.
  bit   voted[N];
  int   m_yes, m_no, m_dups, m_nvoted;
  bit   m_open, m_decide, m_done, m_dup;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) voted[i] = 1'b0;
    m_yes = 0; m_no = 0; m_dups = 0; m_nvoted = 0;
  endtask

  // One cycle: check status outputs, drive inputs for the next edge, predict its effect.
  task automatic cyc(input bit v, input int id, input bit vote, input bit cl, input bit st);
    @(negedge clk);
    chk("ready", int'(ballot_ready), int'(m_open));
    chk("busy", int'(busy), int'(m_open | m_decide));
    chk("done", int'(done), int'(m_done));
    chk("dup_err", int'(dup_err), int'(m_dup));
    ballot_valid = v;
    ballot_id    = ID_W'(id);
    ballot_vote  = vote;
    close        = cl;
    start        = st;
    m_dup        = 1'b0;
    if (m_open) begin
      if (v) begin
        if (!voted[id]) begin
          voted[id] = 1'b1;
          m_nvoted++;
          if (vote) m_yes++;
          else      m_no++;
        end else begin
          m_dups++;
          m_dup = 1'b1;
        end
      end
      if (cl || m_nvoted == N) begin
        m_open   = 1'b0;
        m_decide = 1'b1;
        sb.push_back('{m_yes, m_no, int'(m_yes > m_no), int'(m_yes == m_no), m_dups});
      end
    end else if (m_decide) begin
      m_decide = 1'b0;
      m_done   = 1'b1;
    end else if (st) begin
      m_open = 1'b1;
      m_done = 1'b0;
      model_clear();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, int'(ballot_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_tie"}, int'(tie), 0);
    chk({tag, "_yes"}, int'(yes_cnt), 0);
    chk({tag, "_no"}, int'(no_cnt), 0);
    chk({tag, "_dup"}, int'(dup_err), 0);
  endtask

  // Monitor: each rising done retires one scoreboard entry.
  int mon_dups = 0;
  bit done_q = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_dups = 0;
      done_q   = 1'b0;
    end else begin
      if (dup_err) mon_dups++;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending election at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("yes_cnt", int'(yes_cnt), e.yes);
          chk("no_cnt", int'(no_cnt), e.no);
          chk("result", int'(result), e.res);
          chk("tie", int'(tie), e.tie);
          chk("dup_pulses", mon_dups, e.dup);
        end
        mon_dups = 0;
      end
      done_q = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int perm[N];
    int tmp, j, sent, guard;
    m_open = 0; m_decide = 0; m_done = 0; m_dup = 0;
    model_clear();

    #12 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ballot in IDLE is ignored, then a full back-to-back election 5 yes / 3 no.
    cyc(1'b1, 1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) cyc(1'b1, i, (i < 5), 1'b0, 1'b0);
    idle(3);
    cyc(1'b1, 2, 1'b1, 1'b0, 1'b0);
    idle(1);

    // 4 yes / 4 no in shuffled order with gappy valid.
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    sent = 0;
    while (sent < N) begin
      if ($urandom_range(0, 1) == 1) begin
        cyc(1'b1, perm[sent], (sent < 4), 1'b0, 1'b0);
        sent++;
      end else begin
        cyc(1'b0, $urandom_range(0, N - 1), 1'b1, 1'b0, 1'b0);
      end
    end
    idle(3);

    // Duplicate id is consumed with a single dup_err pulse.
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Close coincident with the third no ballot still counts it.
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reset mid-election aborts; a following election starts fresh.
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, i, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    ballot_valid = 1'b0; start = 1'b0; close = 1'b0;
    m_open = 0; m_decide = 0; m_done = 0; m_dup = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Empty election closed, with a start during collection ignored.
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Random elections with duplicates, early close, and start noise.
    for (int e = 0; e < 25; e++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, N - 1), 1'b1, 1'b0, 1'b1);
      guard = 0;
      while (m_open) begin
        guard++;
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, N - 1), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 29) == 0) || (guard > 300), $urandom_range(0, 7) == 0);
      end
      for (int k = 0; k < 2 + $urandom_range(0, 2); k++)
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, N - 1), 1'b1, 1'b0, 1'b0);
    end

    idle(4);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
